// File: rtl/corner_overlay.sv
// Purpose : draws crosshair markers at four corners over live video; the selected corner blinks.
// Latency : fixed 2 clocks from hcount/vcount/pixel_in/syncs to pixel_out/syncs_out.
// Backpr. : none; one pixel is accepted and one produced every clock.
//
// Ports:
//   clk, reset_n            pixel clock, synchronous active-low reset
//   corners_x/corners_y     four packed 10-bit corner coordinates (corner k at [10k+9:10k])
//   selected                index of the corner being edited
//   field_edge              one-cycle pulse at field start; loads shadows, advances blink
//   hcount/vcount           current raster position
//   hsync_in/vsync_in/blank_in, pixel_in   upstream timing and RGB
//   pixel_out, hsync_out/vsync_out/blank_out   overlaid RGB and aligned timing
module corner_overlay #(
    parameter int          MARKER_R     = 4,
    parameter int          BLINK_FIELDS = 15,
    parameter logic [23:0] SEL_COLOR    = 24'hFFFF00,
    parameter logic [23:0] UNSEL_COLOR  = 24'hFF0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [39:0] corners_x,
    input  logic [39:0] corners_y,
    input  logic [1:0]  selected,
    input  logic        field_edge,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        blank_in,
    input  logic [23:0] pixel_in,
    output logic [23:0] pixel_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        blank_out
);

    // Reset corner positions: c0 (0,0), c1 (639,0), c2 (639,479), c3 (0,479)
    localparam logic [39:0]        LP_RST_X   = {10'd0,   10'd639, 10'd639, 10'd0};
    localparam logic [39:0]        LP_RST_Y   = {10'd479, 10'd479, 10'd0,   10'd0};
    localparam logic signed [11:0] LP_R       = 12'(MARKER_R);
    localparam logic [4:0]         LP_BLK_LST = 5'(BLINK_FIELDS - 1);

    // Shadow copies: drawing only ever sees values latched at a field boundary
    logic [39:0] r_sh_x;
    logic [39:0] r_sh_y;
    logic [1:0]  r_sh_sel;
    logic [4:0]  r_fcnt;
    logic        r_blink_on;

    // Stage 1
    logic [3:0]  r_s1_hit;
    logic [3:0]  r_s1_sel_oh;
    logic        r_s1_blink;
    logic [23:0] r_s1_pix;
    logic        r_s1_hs;
    logic        r_s1_vs;
    logic        r_s1_blank;

    // Stage 2
    logic [23:0] r_pix_out;
    logic        r_hs_out;
    logic        r_vs_out;
    logic        r_blank_out;

    logic signed [11:0] w_dx [4];
    logic signed [11:0] w_dy [4];
    logic [3:0]         w_hit;
    logic [3:0]         w_sel_oh;
    logic               w_sel_hit;
    logic               w_unsel_hit;
    logic [23:0]        w_color;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sh_x     <= LP_RST_X;
            r_sh_y     <= LP_RST_Y;
            r_sh_sel   <= 2'd0;
            r_fcnt     <= 5'd0;
            r_blink_on <= 1'b1;
        end else if (field_edge) begin
            r_sh_x   <= corners_x;
            r_sh_y   <= corners_y;
            r_sh_sel <= selected;
            if (r_fcnt == LP_BLK_LST) begin
                r_fcnt     <= 5'd0;
                r_blink_on <= ~r_blink_on;
            end else begin
                r_fcnt <= r_fcnt + 5'd1;
            end
        end
    end

    // Offsets are computed wide and signed so a corner near 0 never wraps
    // onto the far edge of the raster; off-screen arm pixels simply never occur.
    always_comb begin
        w_hit = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            w_dx[k]  = $signed({1'b0, hcount}) - $signed({2'b00, r_sh_x[10*k +: 10]});
            w_dy[k]  = $signed({2'b00, vcount}) - $signed({2'b00, r_sh_y[10*k +: 10]});
            w_hit[k] = ((w_dy[k] == 12'sd0) && (w_dx[k] >= -LP_R) && (w_dx[k] <= LP_R)) ||
                       ((w_dx[k] == 12'sd0) && (w_dy[k] >= -LP_R) && (w_dy[k] <= LP_R));
        end
    end

    assign w_sel_oh = 4'b0001 << r_sh_sel;

    // Blink state travels with the pixel so a field edge never changes the
    // appearance of a pixel already in stage 1.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s1_hit    <= 4'b0000;
            r_s1_sel_oh <= 4'b0000;
            r_s1_blink  <= 1'b0;
            r_s1_pix    <= 24'd0;
            r_s1_hs     <= 1'b0;
            r_s1_vs     <= 1'b0;
            r_s1_blank  <= 1'b1;   // slot in flight right after reset emerges blanked
        end else begin
            r_s1_hit    <= w_hit;
            r_s1_sel_oh <= w_sel_oh;
            r_s1_blink  <= r_blink_on;
            r_s1_pix    <= pixel_in;
            r_s1_hs     <= hsync_in;
            r_s1_vs     <= vsync_in;
            r_s1_blank  <= blank_in;
        end
    end

    // Selected marker (when lit) beats unselected ones; a dark selected marker
    // falls through so an overlapping unselected marker still shows.
    always_comb begin
        w_sel_hit   = |(r_s1_hit & r_s1_sel_oh);
        w_unsel_hit = |(r_s1_hit & ~r_s1_sel_oh);
        w_color     = r_s1_pix;
        if (r_s1_blank) begin
            w_color = 24'd0;
        end else if (w_sel_hit && r_s1_blink) begin
            w_color = SEL_COLOR;
        end else if (w_unsel_hit) begin
            w_color = UNSEL_COLOR;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pix_out   <= 24'd0;
            r_hs_out    <= 1'b0;
            r_vs_out    <= 1'b0;
            r_blank_out <= 1'b1;
        end else begin
            r_pix_out   <= w_color;
            r_hs_out    <= r_s1_hs;
            r_vs_out    <= r_s1_vs;
            r_blank_out <= r_s1_blank;
        end
    end

    assign pixel_out = r_pix_out;
    assign hsync_out = r_hs_out;
    assign vsync_out = r_vs_out;
    assign blank_out = r_blank_out;

endmodule

// File: tb/tb_corner_overlay.sv
module tb_corner_overlay;

    localparam logic [23:0] SEL   = 24'hFFFF00;
    localparam logic [23:0] UNSEL = 24'hFF0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [39:0] corners_x = '0;
    logic [39:0] corners_y = '0;
    logic [1:0]  selected = 2'd0;
    logic        field_edge = 1'b0;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic        blank_in = 1'b1;
    logic [23:0] pixel_in = '0;
    logic [23:0] pixel_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        blank_out;

    corner_overlay dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .corners_x  (corners_x),
        .corners_y  (corners_y),
        .selected   (selected),
        .field_edge (field_edge),
        .hcount     (hcount),
        .vcount     (vcount),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .blank_in   (blank_in),
        .pixel_in   (pixel_in),
        .pixel_out  (pixel_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .blank_out  (blank_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [23:0] pix;
        logic        hs;
        logic        vs;
        logic        bl;
        int          h;
        int          v;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   fe_count = 0;

    function automatic logic [23:0] pat(input int h, input int v);
        logic [7:0] a;
        logic [7:0] b;
        a = 8'(h);
        b = 8'(v);
        return {a, b, 8'h5A};
    endfunction

    // Blink starts on and flips every BLINK_FIELDS (15) field edges.
    function automatic bit blink_exp();
        return ((fe_count / 15) % 2) == 0;
    endfunction

    // Scoreboard side: outputs are compared 2 clocks after the inputs were applied.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                total = total + 1;
                if (pixel_out !== e.pix || hsync_out !== e.hs || vsync_out !== e.vs || blank_out !== e.bl) begin
                    bad = bad + 1;
                    $display("FAIL pixel h=%0d v=%0d got pix=%h hs=%b vs=%b bl=%b want pix=%h hs=%b vs=%b bl=%b",
                             e.h, e.v, pixel_out, hsync_out, vsync_out, blank_out, e.pix, e.hs, e.vs, e.bl);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic drive(input int h, input int v, input logic bl, input logic fe, input logic [23:0] want);
        exp_t e;
        @(negedge clk);
        hcount     = 11'(h);
        vcount     = 10'(v);
        blank_in   = bl;
        field_edge = fe;
        pixel_in   = pat(h, v);
        hsync_in   = h[0];
        vsync_in   = v[1];
        e.due = cyc + 2;
        e.pix = bl ? 24'd0 : want;
        e.hs  = h[0];
        e.vs  = v[1];
        e.bl  = bl;
        e.h   = h;
        e.v   = v;
        exp_q.push_back(e);
        if (fe) fe_count = fe_count + 1;
    endtask

    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1000, 1000, 1'b1, 1'b1, 24'd0);
            drive(1000, 1000, 1'b1, 1'b0, 24'd0);
        end
    endtask

    task automatic flush();
        @(negedge clk);
        field_edge = 1'b0;
        blank_in   = 1'b1;
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total = total + 1;
        if (pixel_out !== 24'd0 || hsync_out !== 1'b0 || vsync_out !== 1'b0 || blank_out !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL reset_outputs got pix=%h hs=%b vs=%b bl=%b want 000000 0 0 1",
                     pixel_out, hsync_out, vsync_out, blank_out);
        end
        @(negedge clk);
        reset_n = 1'b1;
        // Default shadows: c0 (0,0) selected and lit, c2 (639,479) unselected
        for (int h = 0; h < 7; h++)
            drive(h, 0, 1'b0, 1'b0, (h <= 4) ? SEL : pat(h, 0));
        drive(637, 479, 1'b0, 1'b0, UNSEL);
        drive(639, 476, 1'b0, 1'b0, UNSEL);
        drive(639, 474, 1'b0, 1'b0, pat(639, 474));
        flush();
    endtask

    task automatic test_unsel_row();
        corners_x = {10'd0,   10'd639, 10'd200, 10'd100};
        corners_y = {10'd479, 10'd479, 10'd200, 10'd50};
        selected  = 2'd1;
        pulse(1);
        for (int h = 94; h <= 106; h++)
            drive(h, 50, 1'b0, 1'b0, (h >= 96 && h <= 104) ? UNSEL : pat(h, 50));
        flush();
    endtask

    task automatic test_blink();
        for (int pass = 0; pass < 3; pass++) begin
            for (int v = 195; v <= 205; v++)
                drive(200, v, 1'b0, 1'b0,
                      (v >= 196 && v <= 204 && blink_exp()) ? SEL : pat(200, v));
            if (pass < 2) pulse(15);
        end
        flush();
    endtask

    task automatic test_shadow();
        corners_x[9:0] = 10'd400;
        for (int h = 98; h <= 102; h++) drive(h, 50, 1'b0, 1'b0, UNSEL);
        for (int h = 398; h <= 402; h++) drive(h, 50, 1'b0, 1'b0, pat(h, 50));
        // Pixel launched with the field edge still sees the old marker
        drive(100, 50, 1'b0, 1'b1, UNSEL);
        drive(100, 50, 1'b0, 1'b0, pat(100, 50));
        for (int h = 395; h <= 405; h++)
            drive(h, 50, 1'b0, 1'b0, (h >= 396 && h <= 404) ? UNSEL : pat(h, 50));
        flush();
    endtask

    task automatic test_clip();
        corners_x[9:0] = 10'd0;
        corners_y[9:0] = 10'd0;
        pulse(1);
        for (int h = 0; h <= 6; h++)
            drive(h, 0, 1'b0, 1'b0, (h <= 4) ? UNSEL : pat(h, 0));
        for (int h = 2043; h <= 2047; h++)
            drive(h, 0, 1'b0, 1'b0, pat(h, 0));
        for (int v = 1; v <= 6; v++)
            drive(0, v, 1'b0, 1'b0, (v <= 4) ? UNSEL : pat(0, v));
        drive(0, 1020, 1'b0, 1'b0, pat(0, 1020));
        flush();
    endtask

    task automatic test_overlap();
        corners_x = {10'd0,   10'd639, 10'd300, 10'd300};
        corners_y = {10'd479, 10'd479, 10'd300, 10'd300};
        selected  = 2'd1;
        pulse(1);
        for (int pass = 0; pass < 2; pass++) begin
            drive(300, 300, 1'b0, 1'b0, blink_exp() ? SEL : UNSEL);
            drive(304, 300, 1'b0, 1'b0, blink_exp() ? SEL : UNSEL);
            drive(300, 296, 1'b0, 1'b0, blink_exp() ? SEL : UNSEL);
            drive(305, 300, 1'b0, 1'b0, pat(305, 300));
            if (pass == 0) pulse(15);
        end
        flush();
    endtask

    task automatic test_blank_and_reset();
        drive(300, 300, 1'b1, 1'b0, 24'd0);
        drive(301, 300, 1'b0, 1'b0, blink_exp() ? SEL : UNSEL);
        drive(302, 300, 1'b0, 1'b0, blink_exp() ? SEL : UNSEL);
        drive(303, 300, 1'b0, 1'b0, blink_exp() ? SEL : UNSEL);
        // Reset lands mid-row; in-flight pixels are discarded
        @(negedge clk);
        reset_n = 1'b0;
        hcount  = 11'd304;
        exp_q.delete();
        @(posedge clk);
        #1;
        total = total + 1;
        if (pixel_out !== 24'd0 || blank_out !== 1'b1 || hsync_out !== 1'b0 || vsync_out !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL midrow_reset got pix=%h bl=%b hs=%b vs=%b want 000000 1 0 0",
                     pixel_out, blank_out, hsync_out, vsync_out);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n  = 1'b1;
        fe_count = 0;
        drive(2, 0, 1'b0, 1'b0, SEL);
        drive(300, 300, 1'b0, 1'b0, pat(300, 300));
        drive(637, 479, 1'b0, 1'b0, UNSEL);
        flush();
    endtask

    initial begin
        test_reset();
        test_unsel_row();
        test_blink();
        test_shadow();
        test_clip();
        test_overlap();
        test_blank_and_reset();
        total = total + 1;
        if (exp_q.size() !== 0) begin
            bad = bad + 1;
            $display("FAIL drain got pending=%0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/corner_overlay.md
# corner_overlay

Display-side consumer of the corner selections made through `human_interface`. Draws a crosshair marker at each of the four user-chosen quadrilateral corners on top of the live video stream. The currently selected corner blinks at a field-derived rate. Sits between the video pixel pipeline and the VGA output stage, and delays sync/blank so they stay aligned with the pixel data.

## Interface

Parameters:
- `MARKER_R`, 4: crosshair arm length in pixels; each arm spans center ± `MARKER_R`.
- `BLINK_FIELDS`, 15: number of `field_edge` pulses per blink half-period.
- `SEL_COLOR`, 24'hFFFF00: RGB of the selected corner's marker.
- `UNSEL_COLOR`, 24'hFF0000: RGB of unselected markers.

Ports:
- `clk` input 1: pixel clock.
- `reset_n` input 1: synchronous, active-low reset.
- `corners_x` input 40: four 10-bit x coordinates; corner k at [10k+9:10k].
- `corners_y` input 40: four 10-bit y coordinates, same packing.
- `selected` input 2: index of the corner currently being edited.
- `field_edge` input 1: one-cycle pulse at the start of each field.
- `hcount` input 11: current pixel column.
- `vcount` input 10: current pixel row.
- `hsync_in`, `vsync_in`, `blank_in` input 1 each: raw timing signals.
- `pixel_in` input 24: RGB from the upstream pipeline.
- `pixel_out` output 24: overlaid RGB.
- `hsync_out`, `vsync_out`, `blank_out` output 1 each: timing delayed to match `pixel_out`.

## Operation

Shadow registers:
- `corners_x`, `corners_y` and `selected` are copied into shadow registers only on a cycle where `field_edge` = 1.
- All drawing uses the shadow copies, so markers never tear mid-field.
- Reset values: (0,0), (639,0), (639,479), (0,479); `selected` = 0.

Blink:
- A field counter (5 bits) increments on each `field_edge`.
- When it reaches `BLINK_FIELDS`-1 and another `field_edge` arrives, the counter clears and `blink_on` toggles.
- Reset: counter = 0, `blink_on` = 1.

Hit test for corner k:
- dx = `hcount` − cx_k and dy = {1'b0,`vcount`} − cy_k, both computed 12-bit signed; no wrap.
- hit_k = (dy == 0 and |dx| ≤ `MARKER_R`) or (dx == 0 and |dy| ≤ `MARKER_R`).
- Arms that fall off-screen (e.g. corner at x = 0) are clipped naturally, because hcount/vcount never go negative.

Color select, in priority order:
1. `blank` stage-delayed = 1 → output 0.
2. Hit on the shadow-selected corner and `blink_on` = 1 → `SEL_COLOR`.
3. Hit on any unselected corner → `UNSEL_COLOR`.
4. Otherwise → `pixel_in` (delayed).

Overlap and blink-off rules:
- Overlapping markers: rule 2 wins over rule 3.
- Selected corner during blink-off: shows the pixel underneath, unless an unselected marker overlaps it, in which case `UNSEL_COLOR`.

Field edge coinciding with shadow update:
- When `field_edge` also toggles `blink_on` in the same cycle, both take effect on the next clock.
- Stage-1 pixels already in flight use the old values.

## Timing

- Pipeline is 2 stages with fixed latency of 2 clocks from `hcount`/`vcount`/`pixel_in`/syncs to `pixel_out`/syncs_out.
- Stage 1 registers:
  - the four hit flags,
  - a one-hot of the selected corner,
  - `pixel_in`, `hsync_in`, `vsync_in`, `blank_in`.
- Stage 2 registers the color mux result and the delayed syncs.
- Reset:
  - all pipeline registers clear;
  - `pixel_out` = 0, `hsync_out` = 0, `vsync_out` = 0, `blank_out` = 1.
- Reset asserted mid-line:
  - outputs take their reset values on the next clock;
  - in-flight pixels are discarded;
  - normal output resumes 2 clocks after `reset_n` rises.
- No handshake; one pixel is accepted and produced every clock.

## Test plan

- Reset, then `field_edge` pulse with corner0 = (100,50), `selected` = 1; scan row 50 → `pixel_out` = FF0000 for hcount 96..104, and `pixel_in` passthrough at hcount 95 and 105, each exactly 2 clocks later.
- Selected corner1 = (200,200), `blink_on` = 1; column 200 at rows 196..204 → FFFF00. After 15 `field_edge` pulses, same scan → passthrough. After 15 more → FFFF00 again.
- Change `corners_x` with no `field_edge`, scan → markers stay at the old positions; pulse `field_edge` → markers move on the next scan.
- Corner at (0,0) → row 0 drawn for hcount 0..4 only; column 0 drawn for vcount 0..4; no wrapped pixels at hcount 2044+.
- Selected and unselected corners both at (300,300), blink off → FF0000; blink on → FFFF00.
- `blank_in` = 1 over a hit pixel → `pixel_out` = 0. Pull `reset_n` low mid-row → next clock `pixel_out` = 0 and `blank_out` = 1.
